otl_spi_arb: RTL and testbench
==============================

OTL_SPI_ARB -- requirements
Module: otl_spi_arb

Interface
REQ-001 The block SHALL have parameter WR_W, default 16, meaning SPI write word width.
REQ-002 The block SHALL have parameter RD_W, default 8, meaning SPI read word width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1024, meaning the maximum number of sys_clk cycles to wait for spi_done.
REQ-004 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have ports req0 and req1, input, 1 bit each: requester transaction request, level.
REQ-007 The block SHALL have ports wdata0 and wdata1, input, WR_W bits each: requester write word, held stable while req is high.
REQ-008 The block SHALL have ports gnt0 and gnt1, output, 1 bit each: 1-cycle pulse when the request is accepted.
REQ-009 The block SHALL have ports done0 and done1, output, 1 bit each: 1-cycle pulse when the transaction completes.
REQ-010 The block SHALL have port rdata, output, RD_W bits: read word, valid while done0 or done1 is high.
REQ-011 The block SHALL have port err, output, 1 bit: timeout flag, valid while done0 or done1 is high.
REQ-012 The block SHALL have port spi_wr_data, output, WR_W bits: word driven to the SPI master wr_data.
REQ-013 The block SHALL have port spi_wr, output, 1 bit: driven to the SPI master wr, constant 1 after reset.
REQ-014 The block SHALL have port spi_new_data, output, 1 bit: 1-cycle start pulse to the SPI master.
REQ-015 The block SHALL have ports spi_busy, spi_done (1 bit each) and spi_rd_data (RD_W bits), all inputs, driven by the SPI master.

Function
REQ-016 The FSM SHALL have states IDLE, LAUNCH, WAIT and FINISH.
REQ-017 In IDLE with spi_busy=0 and any req high, the block SHALL select a winner and go to LAUNCH next cycle; with spi_busy=1 it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: on a tie, the requester not granted last wins; after reset, requester 0 has priority.
REQ-019 In LAUNCH, for exactly one cycle, the block SHALL assert spi_new_data=1 and the winner's gnt=1, with spi_wr_data = the winner's wdata captured on the IDLE->LAUNCH edge; the next state is WAIT.
REQ-020 spi_wr_data SHALL hold the captured word from LAUNCH until FINISH ends.
REQ-021 In WAIT, on spi_done=1 the block SHALL capture spi_rd_data and go to FINISH.
REQ-022 In WAIT, a cycle counter SHALL increment each cycle; on reaching TIMEOUT_CYC-1 without spi_done, the block SHALL go to FINISH with the error path selected.
REQ-023 In FINISH, for exactly one cycle, the winner's done SHALL be 1, with rdata = the captured word and err=0; on timeout, rdata=0 and err=1; the next state is IDLE.
REQ-024 Minimum latency SHALL be: req seen in IDLE at cycle N -> gnt at N+1 -> done one cycle after the spi_done cycle.
REQ-025 req and wdata SHALL be ignored from LAUNCH through FINISH; a req still high in IDLE after FINISH SHALL be a new request.
REQ-026 A req deasserted before grant SHALL be dropped without side effects.
REQ-027 spi_done outside WAIT SHALL be ignored.
REQ-028 gnt0/gnt1 SHALL be mutually exclusive, done0/done1 SHALL be mutually exclusive, and at most one transaction SHALL be in flight.
REQ-029 rdata and err SHALL be 0 whenever no done is high.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL set the state to IDLE, the counter to 0, the round-robin pointer to favour requester 0, and gnt*, done*, spi_new_data, err, rdata, spi_wr_data all to 0, with spi_wr=1.
REQ-031 A reset asserted mid-transaction SHALL abort it with no done pulse; after reset releases, the next transaction starts from IDLE.

Structure
REQ-032 The state encoding, the default widths and the TIMEOUT default SHALL reside in the shared package otl_spi_pkg.
REQ-033 The round-robin selection SHALL be a sub-module otl_rr_arb2 (inputs req[1:0], update, clk, reset; outputs onehot grant, last pointer).

Verification
REQ-034 The bench SHALL cover: req0, wdata0=16'habcd; the SPI model returns spi_done after 40 cycles with rd=8'h5a -> gnt0 one cycle after req, spi_wr_data=abcd, done0 with rdata=5a and err=0.
REQ-035 The bench SHALL cover: req0 and req1 high together, repeated for 4 transactions -> grant order 0,1,0,1 and no overlap of spi_new_data.
REQ-036 The bench SHALL cover: TIMEOUT_CYC=16 with spi_done never asserted -> done at cycle 16 after LAUNCH with err=1 and rdata=0.
REQ-037 The bench SHALL cover: reset pulsed in WAIT -> no done pulse, all outputs 0 except spi_wr=1, and the next req serviced normally.
REQ-038 The bench SHALL cover: spi_busy=1 while req1 is high -> no gnt until spi_busy falls, then gnt1 on the next cycle.
REQ-039 The bench SHALL cover: a spurious spi_done in IDLE -> no done pulse and no state change.

Source files
------------

// File: rtl/otl_spi_pkg.sv
// Shared definitions for the two-requester SPI arbiter: FSM encoding,
// default widths/timeout and the round-robin pick rule.
package otl_spi_pkg;

  localparam int DEF_WR_W        = 16;
  localparam int DEF_RD_W        = 8;
  localparam int DEF_TIMEOUT_CYC = 1024;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // On a tie the requester that was not granted last wins; last=1 favours requester 0.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] g;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/otl_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered
// pointer holding the index of the requester granted last.
module otl_rr_arb2
  import otl_spi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant,
  output logic       last
);

  assign grant = rr_pick(req, last);

  // Pointer update on an accepted grant; reset favours requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (update) begin
      last <= grant[1];
    end else begin
      last <= last;
    end
  end

endmodule

// File: rtl/otl_spi_arb.sv
// Shares one SPI master between two requesters, one transaction at a time,
// with round-robin arbitration and a spi_done timeout.
module otl_spi_arb
  import otl_spi_pkg::*;
#(
  parameter int WR_W        = DEF_WR_W,
  parameter int RD_W        = DEF_RD_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic            sys_clk,
  input  logic            reset,
  input  logic            req0,
  input  logic            req1,
  input  logic [WR_W-1:0] wdata0,
  input  logic [WR_W-1:0] wdata1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            done0,
  output logic            done1,
  output logic [RD_W-1:0] rdata,
  output logic            err,
  output logic [WR_W-1:0] spi_wr_data,
  output logic            spi_wr,
  output logic            spi_new_data,
  input  logic            spi_busy,
  input  logic            spi_done,
  input  logic [RD_W-1:0] spi_rd_data
);

  // The WAIT counter starts at 0, so CNT_LAST is the value at which cnt+1 reaches TIMEOUT_CYC-1.
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 2);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant;
  logic             last;
  logic             accept;

  assign accept = (state == ST_IDLE) && !spi_busy && (req0 || req1);

  // After the accepting edge, last is the index of the transaction in flight.
  otl_rr_arb2 u_rr (
    .clk    (sys_clk),
    .reset  (reset),
    .req    ({req1, req0}),
    .update (accept),
    .grant  (grant),
    .last   (last)
  );

  // Transaction FSM; all outputs are registered, pulses default low each cycle.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= {CNT_W{1'b0}};
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      rdata        <= {RD_W{1'b0}};
      err          <= 1'b0;
      spi_wr_data  <= {WR_W{1'b0}};
      spi_wr       <= 1'b1;
      spi_new_data <= 1'b0;
    end else begin
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      rdata        <= {RD_W{1'b0}};
      err          <= 1'b0;
      spi_wr       <= 1'b1;
      spi_new_data <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state        <= ST_LAUNCH;
            gnt0         <= grant[0];
            gnt1         <= grant[1];
            spi_new_data <= 1'b1;
            spi_wr_data  <= grant[1] ? wdata1 : wdata0;
          end
        end
        ST_LAUNCH: begin
          cnt   <= {CNT_W{1'b0}};
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (spi_done) begin
            state <= ST_FINISH;
            done0 <= ~last;
            done1 <= last;
            rdata <= spi_rd_data;
          end else if (cnt == CNT_LAST) begin
            state <= ST_FINISH;
            done0 <= ~last;
            done1 <= last;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otl_spi_arb.sv
// Self-checking bench for otl_spi_arb: a behavioural SPI master model plus a
// round-robin reference computed from the arbitration rules.
module tb_otl_spi_arb;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err, spi_wr, spi_new_data;
  logic [7:0]  rdata;
  logic [15:0] spi_wr_data;
  logic        spi_busy, spi_done;
  logic [7:0]  spi_rd_data;

  logic        req0_t, req1_t;
  logic [15:0] wdata0_t, wdata1_t;
  logic        gnt0_t, gnt1_t, done0_t, done1_t, err_t, spi_wr_t, spi_new_data_t;
  logic [7:0]  rdata_t;
  logic [15:0] spi_wr_data_t;
  logic        spi_busy_t, spi_done_t;
  logic [7:0]  spi_rd_data_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         spi_lat = 4;
  logic [7:0] spi_rd_val = 8'h00;
  bit         m_active = 1'b0;
  bit         m_done_set = 1'b0;
  int         m_cnt = 0;
  bit         rr_last;

  otl_spi_arb dut (
    .sys_clk(sys_clk), .reset(reset), .req0(req0), .req1(req1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .rdata(rdata), .err(err),
    .spi_wr_data(spi_wr_data), .spi_wr(spi_wr), .spi_new_data(spi_new_data),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_rd_data(spi_rd_data)
  );

  otl_spi_arb #(.TIMEOUT_CYC(16)) dut_to (
    .sys_clk(sys_clk), .reset(reset), .req0(req0_t), .req1(req1_t),
    .wdata0(wdata0_t), .wdata1(wdata1_t), .gnt0(gnt0_t), .gnt1(gnt1_t),
    .done0(done0_t), .done1(done1_t), .rdata(rdata_t), .err(err_t),
    .spi_wr_data(spi_wr_data_t), .spi_wr(spi_wr_t), .spi_new_data(spi_new_data_t),
    .spi_busy(spi_busy_t), .spi_done(spi_done_t), .spi_rd_data(spi_rd_data_t)
  );

  initial forever #5 sys_clk = ~sys_clk;
  initial forever begin @(posedge sys_clk); cyc++; end

  // SPI master model: busy from start pulse, spi_done spi_lat cycles later.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (m_done_set) begin spi_done = 1'b0; m_done_set = 1'b0; end
      if (reset) begin
        m_active = 1'b0;
        spi_busy = 1'b0;
      end else if (m_active) begin
        if (m_cnt <= 1) begin
          spi_done = 1'b1; spi_rd_data = spi_rd_val; m_done_set = 1'b1;
          m_active = 1'b0; spi_busy = 1'b0;
        end else begin
          m_cnt--;
        end
      end else if (spi_new_data === 1'b1) begin
        m_active = 1'b1; m_cnt = spi_lat; spi_busy = 1'b1;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int at, output bit ok);
    ok = 1'b0; at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge sys_clk);
      if (done0 || done1) begin at = cyc; ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [30:0] got, exp_v;
    reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    exp_v = {22'd0, 8'd0, 1'b1};
    exp_v = {6'd0, 8'd0, 16'd0, 1'b1};
    got = {gnt0, gnt1, done0, done1, spi_new_data, err, rdata, spi_wr_data, spi_wr};
    checks++;
    if (got !== exp_v) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", got, exp_v); end
    got = {gnt0_t, gnt1_t, done0_t, done1_t, spi_new_data_t, err_t, rdata_t, spi_wr_data_t, spi_wr_t};
    checks++;
    if (got !== exp_v) begin failures++; $display("FAIL reset_outputs_to got=%h exp=%h", got, exp_v); end
    reset = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_single();
    int l, at; bit ok;
    spi_lat = 40; spi_rd_val = 8'h5a;
    req0 = 1'b1; wdata0 = 16'habcd;
    @(negedge sys_clk);
    l = cyc;
    checks++;
    if ({gnt0, gnt1, spi_new_data, spi_wr_data} !== {3'b101, 16'habcd}) begin
      failures++; $display("FAIL single_grant got=%b%b%b %h exp=101 abcd", gnt0, gnt1, spi_new_data, spi_wr_data);
    end
    req0 = 1'b0;
    wait_done(200, at, ok);
    checks++;
    if (!ok || at != l + 41) begin failures++; $display("FAIL single_done_cycle got=%0d exp=%0d", at, l + 41); end
    checks++;
    if ({done0, done1, err, rdata, spi_wr_data} !== {3'b100, 8'h5a, 16'habcd}) begin
      failures++; $display("FAIL single_done got=%b%b%b %h %h exp=100 5a abcd", done0, done1, err, rdata, spi_wr_data);
    end
    @(negedge sys_clk);
    checks++;
    if ({done0, done1, err, rdata} !== 11'd0) begin
      failures++; $display("FAIL single_after got=%b%b%b %h exp=000 00", done0, done1, err, rdata);
    end
  endtask

  task automatic test_rr();
    int n_gnt, n_done; bit inflight; bit cur_w; bit w;
    do_reset();
    spi_lat = $urandom_range(1, 6); spi_rd_val = 8'($urandom);
    wdata0 = 16'($urandom); wdata1 = 16'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    n_gnt = 0; n_done = 0; inflight = 1'b0; cur_w = 1'b0;
    for (int i = 0; i < 400 && n_done < 4; i++) begin
      @(negedge sys_clk);
      if (spi_new_data || gnt0 || gnt1) begin
        w = gnt1;
        checks++;
        if (inflight || (gnt0 == gnt1) || !spi_new_data) begin
          failures++; $display("FAIL rr_overlap inflight=%0d gnt=%b%b new=%b", inflight, gnt0, gnt1, spi_new_data);
        end
        checks++;
        if (w != n_gnt[0] || spi_wr_data !== (w ? wdata1 : wdata0)) begin
          failures++; $display("FAIL rr_order grant#%0d got=%0d data=%h exp=%0d", n_gnt, w, spi_wr_data, n_gnt % 2);
        end
        cur_w = w; inflight = 1'b1; n_gnt++;
        if (n_gnt == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
      if (done0 || done1) begin
        checks++;
        if ({done0, done1} !== (cur_w ? 2'b01 : 2'b10) || rdata !== spi_rd_val) begin
          failures++; $display("FAIL rr_done got=%b%b %h exp_w=%0d %h", done0, done1, rdata, cur_w, spi_rd_val);
        end
        inflight = 1'b0; n_done++;
      end
    end
    checks++;
    if (n_done != 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", n_done); end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_timeout();
    int l, at;
    spi_rd_data_t = 8'hff;
    req0_t = 1'b1; wdata0_t = 16'($urandom);
    @(negedge sys_clk);
    l = cyc;
    checks++;
    if ({gnt0_t, spi_new_data_t} !== 2'b11) begin
      failures++; $display("FAIL to_grant got=%b%b exp=11", gnt0_t, spi_new_data_t);
    end
    req0_t = 1'b0;
    at = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge sys_clk);
      if (done0_t || done1_t) begin at = cyc; break; end
    end
    checks++;
    if (at != l + 16) begin failures++; $display("FAIL to_cycle got=%0d exp=%0d", at, l + 16); end
    checks++;
    if ({done0_t, done1_t, err_t, rdata_t} !== {3'b101, 8'h00}) begin
      failures++; $display("FAIL to_result got=%b%b%b %h exp=101 00", done0_t, done1_t, err_t, rdata_t);
    end
    @(negedge sys_clk);
    checks++;
    if ({done0_t, err_t} !== 2'b00) begin failures++; $display("FAIL to_after got=%b%b exp=00", done0_t, err_t); end
  endtask

  task automatic test_reset_mid();
    logic [30:0] got;
    int seen, l, at; bit ok; logic [15:0] wd;
    spi_lat = 30; spi_rd_val = 8'($urandom);
    req0 = 1'b1; wdata0 = 16'($urandom);
    @(negedge sys_clk);
    req0 = 1'b0;
    repeat (5) @(negedge sys_clk);
    reset = 1'b1;
    @(negedge sys_clk);
    got = {gnt0, gnt1, done0, done1, spi_new_data, err, rdata, spi_wr_data, spi_wr};
    checks++;
    if (got !== {30'd0, 1'b1}) begin failures++; $display("FAIL midreset_outputs got=%h exp=%h", got, {30'd0, 1'b1}); end
    @(negedge sys_clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (done0 || done1 || gnt0 || gnt1) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midreset_quiet got=%0d exp=0", seen); end
    spi_lat = $urandom_range(1, 10); spi_rd_val = 8'($urandom);
    wd = 16'($urandom); req1 = 1'b1; wdata1 = wd;
    @(negedge sys_clk);
    l = cyc;
    checks++;
    if ({gnt0, gnt1, spi_wr_data} !== {2'b01, wd}) begin
      failures++; $display("FAIL midreset_next_grant got=%b%b %h exp=01 %h", gnt0, gnt1, spi_wr_data, wd);
    end
    req1 = 1'b0;
    wait_done(spi_lat + 10, at, ok);
    checks++;
    if (!ok || at != l + spi_lat + 1 || {done0, done1, err, rdata} !== {3'b010, spi_rd_val}) begin
      failures++; $display("FAIL midreset_next_done at=%0d exp=%0d got=%b%b%b %h", at, l + spi_lat + 1, done0, done1, err, rdata);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_busy();
    int k, l, at, bad; bit ok; logic [15:0] wd;
    spi_busy = 1'b1;
    req0 = 1'b1; wdata0 = 16'($urandom);
    bad = 0;
    repeat (2) begin @(negedge sys_clk); if (gnt0 || gnt1 || spi_new_data) bad++; end
    req0 = 1'b0;
    wd = 16'($urandom); req1 = 1'b1; wdata1 = wd;
    k = $urandom_range(3, 8);
    repeat (k) begin @(negedge sys_clk); if (gnt0 || gnt1 || spi_new_data) bad++; end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL busy_hold got=%0d grants exp=0", bad); end
    spi_lat = $urandom_range(1, 10); spi_rd_val = 8'($urandom);
    spi_busy = 1'b0;
    @(negedge sys_clk);
    l = cyc;
    checks++;
    if ({gnt0, gnt1, spi_wr_data} !== {2'b01, wd}) begin
      failures++; $display("FAIL busy_release got=%b%b %h exp=01 %h", gnt0, gnt1, spi_wr_data, wd);
    end
    req1 = 1'b0;
    wait_done(spi_lat + 10, at, ok);
    checks++;
    if (!ok || at != l + spi_lat + 1 || {done0, done1, rdata} !== {2'b01, spi_rd_val}) begin
      failures++; $display("FAIL busy_done at=%0d exp=%0d got=%b%b %h", at, l + spi_lat + 1, done0, done1, rdata);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_spurious();
    int bad, l, at; bit ok; logic [15:0] wd;
    @(negedge sys_clk);
    spi_rd_data = 8'($urandom) | 8'h01;
    spi_done = 1'b1;
    @(negedge sys_clk);
    spi_done = 1'b0;
    bad = 0;
    repeat (4) begin
      if (done0 || done1 || gnt0 || gnt1 || spi_new_data || err || rdata != 8'h00) bad++;
      @(negedge sys_clk);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL spurious_quiet got=%0d exp=0", bad); end
    spi_lat = $urandom_range(1, 10); spi_rd_val = 8'($urandom);
    wd = 16'($urandom); req0 = 1'b1; wdata0 = wd;
    @(negedge sys_clk);
    l = cyc;
    checks++;
    if ({gnt0, gnt1, spi_wr_data} !== {2'b10, wd}) begin
      failures++; $display("FAIL spurious_grant got=%b%b %h exp=10 %h", gnt0, gnt1, spi_wr_data, wd);
    end
    req0 = 1'b0;
    wait_done(spi_lat + 10, at, ok);
    checks++;
    if (!ok || at != l + spi_lat + 1 || {done0, done1, err, rdata} !== {3'b100, spi_rd_val}) begin
      failures++; $display("FAIL spurious_done at=%0d exp=%0d got=%b%b%b %h", at, l + spi_lat + 1, done0, done1, err, rdata);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_random();
    int pat, l, at; bit ok; bit w; logic [15:0] d0, d1;
    do_reset();
    rr_last = 1'b1;
    for (int t = 0; t < 24; t++) begin
      pat = $urandom_range(1, 3);
      d0 = 16'($urandom); d1 = 16'($urandom);
      spi_lat = $urandom_range(1, 12); spi_rd_val = 8'($urandom);
      req0 = (pat != 2); req1 = (pat != 1); wdata0 = d0; wdata1 = d1;
      w = (pat == 3) ? ~rr_last : (pat == 2);
      @(negedge sys_clk);
      l = cyc;
      checks++;
      if ({gnt1, gnt0} !== (w ? 2'b10 : 2'b01) || spi_wr_data !== (w ? d1 : d0)) begin
        failures++; $display("FAIL rand_grant t=%0d pat=%0d got=%b%b %h exp_w=%0d", t, pat, gnt1, gnt0, spi_wr_data, w);
      end
      req0 = 1'b0; req1 = 1'b0;
      rr_last = w;
      wait_done(spi_lat + 10, at, ok);
      checks++;
      if (!ok || at != l + spi_lat + 1 || {done1, done0} !== (w ? 2'b10 : 2'b01) ||
          err !== 1'b0 || rdata !== spi_rd_val) begin
        failures++; $display("FAIL rand_done t=%0d at=%0d exp=%0d got=%b%b%b %h exp_rd=%h", t, at, l + spi_lat + 1, done1, done0, err, rdata, spi_rd_val);
      end
      @(negedge sys_clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; wdata0 = 16'h0000; wdata1 = 16'h0000;
    spi_busy = 1'b0; spi_done = 1'b0; spi_rd_data = 8'h00;
    req0_t = 1'b0; req1_t = 1'b0; wdata0_t = 16'h0000; wdata1_t = 16'h0000;
    spi_busy_t = 1'b0; spi_done_t = 1'b0; spi_rd_data_t = 8'h00;
    test_reset();
    test_single();
    test_rr();
    test_timeout();
    test_reset_mid();
    test_busy();
    test_spurious();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
